// File: rtl/led_status_arbiter.sv
// Shares one tri-colour LED between N_REQ fixed-priority status requesters,
// with a minimum display hold time and optional per-requester blinking.
module led_status_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned PRESCALE    = 2000000,
  parameter int unsigned HOLD_TICKS  = 50,
  parameter int unsigned BLINK_TICKS = 25
) (
  input  logic                 clk_200,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   req_color,
  input  logic [N_REQ-1:0]     req_blink,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 led_red,
  output logic                 led_green,
  output logic                 led_blue
);

  localparam int unsigned TW = (PRESCALE > 1)    ? $clog2(PRESCALE)       : 1;
  localparam int unsigned HW = (HOLD_TICKS > 0)  ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS)    : 1;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state;
  state_t          state_next;
  logic            load;

  logic [TW-1:0]   tick_cnt;
  logic            tick;

  logic [N_REQ-1:0] win_oh;
  logic [2:0]      win_color;
  logic            win_blink;
  logic            any_req;

  logic [HW-1:0]   hold_cnt;
  logic            hold_expired;
  logic [BW-1:0]   blink_cnt;
  logic            phase;
  logic [2:0]      color_q;
  logic            blink_q;

  // Free-running tick prescaler; deliberately not restarted on grant.
  always_ff @(posedge clk_200) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TW'(PRESCALE - 1));

  // Lowest index wins.
  always_comb begin
    win_oh    = '0;
    win_color = '0;
    win_blink = 1'b0;
    any_req   = |req;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req[i] && (win_oh == '0)) begin
        win_oh[i] = 1'b1;
        win_color = req_color[3*i +: 3];
        win_blink = req_blink[i];
      end
    end
  end

  assign hold_expired = (hold_cnt == '0);

  always_ff @(posedge clk_200) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = SHOW;
          load       = 1'b1;
        end
      end
      SHOW: begin
        if (hold_expired) begin
          if (!any_req) begin
            state_next = IDLE;
          end else if (win_oh != grant) begin
            load = 1'b1;
          end
        end
      end
    endcase
  end

  // A same-winner stay keeps the old latch and counters running untouched.
  always_ff @(posedge clk_200) begin
    if (reset) begin
      grant     <= '0;
      color_q   <= '0;
      blink_q   <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (load) begin
      grant     <= win_oh;
      color_q   <= win_color;
      blink_q   <= win_blink;
      hold_cnt  <= HW'(HOLD_TICKS);
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (state_next == IDLE) begin
      grant <= '0;
    end else if (tick) begin
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    busy = (state == SHOW);
    {led_red, led_green, led_blue} = '0;
    if ((state == SHOW) && (phase || !blink_q)) begin
      {led_red, led_green, led_blue} = color_q;
    end
  end

endmodule

// File: tb/tb_led_status_arbiter.sv
// Bench for led_status_arbiter: directed table, corner sequences and a
// random run against a tick-count reference model (HOLD_TICKS=3 and 0).
module tb_led_status_arbiter;

  localparam int P    = 4;
  localparam int HOLD = 3;
  localparam int BL   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] req_color;
  logic [3:0]  req_blink;

  logic [3:0]  g_a, g_b;
  logic        busy_a, busy_b;
  logic        r_a, gn_a, b_a, r_b, gn_b, b_b;
  logic [2:0]  led_a, led_b;

  int total = 0;
  int bad   = 0;

  assign led_a = {r_a, gn_a, b_a};
  assign led_b = {r_b, gn_b, b_b};

  always #5 clk = ~clk;

  led_status_arbiter #(.N_REQ(4), .PRESCALE(P), .HOLD_TICKS(HOLD), .BLINK_TICKS(BL)) u_dut_a (
    .clk_200(clk), .reset(rst), .req(req), .req_color(req_color), .req_blink(req_blink),
    .grant(g_a), .busy(busy_a), .led_red(r_a), .led_green(gn_a), .led_blue(b_a)
  );

  led_status_arbiter #(.N_REQ(4), .PRESCALE(P), .HOLD_TICKS(0), .BLINK_TICKS(BL)) u_dut_b (
    .clk_200(clk), .reset(rst), .req(req), .req_color(req_color), .req_blink(req_blink),
    .grant(g_b), .busy(busy_b), .led_red(r_b), .led_green(gn_b), .led_blue(b_b)
  );

  // Reference model: granted index, ticks elapsed since the grant edge.
  int         m_k = 0;
  int         m_g[2]     = '{-1, -1};
  int         m_since[2] = '{0, 0};
  int         m_hold[2]  = '{HOLD, 0};
  logic [2:0] m_col[2];
  logic       m_bl[2];

  function automatic int winner(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic grant_to(input int m, input int w);
    m_g[m]     = w;
    m_col[m]   = req_color[3*w +: 3];
    m_bl[m]    = req_blink[w];
    m_since[m] = 0;
  endtask

  task automatic model_edge();
    int w;
    int tk;
    w  = winner(req);
    tk = ((m_k % P) == P - 1) ? 1 : 0;
    if (rst) begin
      m_k = 0;
      for (int m = 0; m < 2; m++) m_g[m] = -1;
    end else begin
      m_k++;
      for (int m = 0; m < 2; m++) begin
        if (m_g[m] < 0) begin
          if (w >= 0) grant_to(m, w);
        end else if (m_since[m] >= m_hold[m]) begin
          if (w < 0) m_g[m] = -1;
          else if (w != m_g[m]) grant_to(m, w);
          else m_since[m] += tk;
        end else begin
          m_since[m] += tk;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_grant(input int m);
    if (m_g[m] < 0) return 4'b0000;
    return 4'(1 << m_g[m]);
  endfunction

  function automatic logic [2:0] exp_led(input int m);
    if (m_g[m] < 0) return 3'b000;
    if (!m_bl[m] || (((m_since[m] / BL) % 2) == 0)) return m_col[m];
    return 3'b000;
  endfunction

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    req_blink = 4'b0000;
    clk_step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] blink;
    logic [3:0] eg;
    logic       eb;
    logic [2:0] el;
  } vec_t;

  vec_t tbl[12];

  // slot3=011, slot2=010, slot1=001, slot0=100
  localparam logic [11:0] COLORS = 12'b011_010_001_100;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int first;
    logic [3:0] val;

    rst = 1'b1;
    req = 4'b0000;
    req_blink = 4'b0000;
    req_color = COLORS;

    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000};
    tbl[1]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 3'b010};
    tbl[2]  = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 3'b000};
    tbl[3]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 3'b010};
    tbl[4]  = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b0, 3'b000};
    tbl[5]  = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 1'b1, 3'b001};
    tbl[6]  = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 1'b1, 3'b001};
    tbl[7]  = '{1'b0, 4'b1000, 4'b0000, 4'b0010, 1'b1, 3'b001};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b000};
    tbl[10] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 3'b100};
    tbl[11] = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b1, 3'b100};

    for (int i = 0; i < 12; i++) begin
      rst       = tbl[i].rst;
      req       = tbl[i].req;
      req_blink = tbl[i].blink;
      clk_step();
      check($sformatf("tbl%0d_grant", i), g_a, tbl[i].eg);
      check($sformatf("tbl%0d_busy", i), busy_a, tbl[i].eb);
      check($sformatf("tbl%0d_led", i), led_a, tbl[i].el);
    end

    // Lower priority holder is not preempted until the hold expires.
    do_reset();
    req = 4'b1000;
    clk_step();
    check("t3_grant3", g_a, 4'b1000);
    check("t3_led3", led_a, 3'b011);
    req = 4'b1001;
    first = -1;
    val = 4'b0000;
    for (int n = 1; n <= 20; n++) begin
      clk_step();
      if (first < 0 && g_a !== 4'b1000) begin
        first = n;
        val = g_a;
      end
    end
    check("t3_switch_cycle", first, 12);
    check("t3_switch_grant", val, 4'b0001);
    check("t3_led0", led_a, 3'b100);

    // Blink: 2 ticks on, 2 off; dropping req_blink mid-display is ignored.
    do_reset();
    req = 4'b0001;
    req_blink = 4'b0001;
    clk_step();
    for (int n = 0; n < 24; n++) begin
      check($sformatf("t4_blink_n%0d", n), led_a, ((((n + 1) / 8) % 2) == 0) ? 3'b100 : 3'b000);
      if (n == 10) req_blink = 4'b0000;
      clk_step();
    end

    // Granted req dropped before expiry stays shown until expiry.
    do_reset();
    req = 4'b0100;
    clk_step();
    req = 4'b0000;
    for (int n = 1; n <= 13; n++) begin
      clk_step();
      check($sformatf("t5a_grant_n%0d", n), g_a, (n <= 11) ? 4'b0100 : 4'b0000);
      check($sformatf("t5a_led_n%0d", n), led_a, (n <= 11) ? 3'b010 : 3'b000);
    end

    // Dropped after expiry goes dark on the next edge.
    do_reset();
    req = 4'b0100;
    for (int n = 0; n <= 14; n++) clk_step();
    check("t5b_still_shown", g_a, 4'b0100);
    req = 4'b0000;
    clk_step();
    check("t5b_grant_off", g_a, 4'b0000);
    check("t5b_busy_off", busy_a, 1'b0);
    check("t5b_led_off", led_a, 3'b000);

    // Random run against the reference model, both hold settings.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 255) == 0);
      case ($urandom_range(0, 7))
        0: req = 4'($urandom) & 4'($urandom);
        1: req = 4'($urandom);
        2: req = 4'b0000;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) req_color = 12'($urandom);
      if ($urandom_range(0, 7) == 0) req_blink = 4'($urandom);
      clk_step();
      check("rnd_h3_grant", g_a, exp_grant(0));
      check("rnd_h3_busy", busy_a, exp_grant(0) != 4'b0000);
      check("rnd_h3_led", led_a, exp_led(0));
      check("rnd_h0_grant", g_b, exp_grant(1));
      check("rnd_h0_busy", busy_b, exp_grant(1) != 4'b0000);
      check("rnd_h0_led", led_b, exp_led(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
